// File: rtl/duck_pkg.sv
// Shared types and constants for the duck flight controller slice.
package duck_pkg;

   localparam int COORD_W = 11;

   typedef logic [COORD_W-1:0]        coord_t;
   typedef logic signed [COORD_W:0]   scoord_t;

   typedef enum logic [2:0] {
      IDLE,
      FLY,
      SHOT,
      FALL,
      ESCAPE
   } state_t;

   localparam logic [2:0] SPR_FLY_R0 = 3'd0;
   localparam logic [2:0] SPR_FLY_L0 = 3'd3;
   localparam logic [2:0] SPR_SHOT   = 3'd6;
   localparam logic [2:0] SPR_FALL   = 3'd7;

   function automatic logic [2:0] fly_sprite(input logic left, input logic [1:0] frame);
      return left ? SPR_FLY_L0 + {1'b0, frame} : SPR_FLY_R0 + {1'b0, frame};
   endfunction

endpackage

// File: rtl/duck_flight_ctrl_if.sv
// Control/status bundle between the game logic and the duck flight controller.
interface duck_flight_ctrl_if;
   import duck_pkg::*;

   logic       frame_tick;
   logic       start;
   logic       hit;
   coord_t     xpos;
   coord_t     ypos;
   logic [2:0] sprite_id;
   logic       visible;
   logic       busy;
   logic       shot_done;
   logic       escaped;

   modport master (
      output frame_tick, start, hit,
      input  xpos, ypos, sprite_id, visible, busy, shot_done, escaped
   );

   modport slave (
      input  frame_tick, start, hit,
      output xpos, ypos, sprite_id, visible, busy, shot_done, escaped
   );

endinterface

// File: rtl/duck_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 0xACE1 on reset.
module duck_lfsr (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) value <= 16'hACE1;
      else     value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
   end

endmodule

// File: rtl/duck_flight_ctrl.sv
// Per-round duck sprite sequencer: launch, bouncing flight, shot, fall, escape.
// Optional randomised launch direction/x under macro DUCK_FLIGHT_CTRL_RANDOM_DIR_EN.
module duck_flight_ctrl
   import duck_pkg::*;
#(
   parameter int SCREEN_W    = 800,
   parameter int GROUND_Y    = 450,
   parameter int SPRITE_SIZE = 64,
   parameter int START_X     = 100,
   parameter int START_Y     = 100,
   parameter int SPEED_X     = 2,
   parameter int SPEED_Y     = 2,
   parameter int FALL_SPEED  = 4,
   parameter int ANIM_DIV    = 8,
   parameter int SHOT_FRAMES = 30,
   parameter int FLY_FRAMES  = 600
) (
   input logic               aclk,
   input logic               rst,
   duck_flight_ctrl_if.slave bus
);

   localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int FLY_W  = $clog2(FLY_FRAMES + 1);
   localparam int SHOT_W = $clog2(SHOT_FRAMES + 1);

   localparam scoord_t X_LIM = scoord_t'(SCREEN_W - SPRITE_SIZE);
   localparam scoord_t Y_LIM = scoord_t'(GROUND_Y - SPRITE_SIZE);
   localparam scoord_t SX    = scoord_t'(SPEED_X);
   localparam scoord_t SY    = scoord_t'(SPEED_Y);
   localparam scoord_t FS    = scoord_t'(FALL_SPEED);

   state_t              state, state_n;
   coord_t              xpos_q, xpos_n, ypos_q, ypos_n;
   logic [2:0]          spr_q, spr_n;
   logic                vis_q, vis_n, busy_q, busy_n;
   logic                done_q, done_n, esc_q, esc_n;
   logic                dx_neg, dx_n, dy_neg, dy_n;
   logic [ANIM_W-1:0]   anim_cnt, anim_n, anim_adv;
   logic [1:0]          frame, frame_n, frame_adv;
   logic [FLY_W-1:0]    fly_cnt, fly_n;
   logic [SHOT_W-1:0]   shot_cnt, shot_n;
   scoord_t             nx, ny, fy, ey;
   coord_t              launch_x;
   logic                launch_left;

`ifdef DUCK_FLIGHT_CTRL_RANDOM_DIR_EN
   logic [15:0] lfsr;
   scoord_t     launch_sum;

   duck_lfsr u_lfsr (
      .clk   (aclk),
      .rst   (rst),
      .value (lfsr)
   );

   assign launch_left = lfsr[0];
   assign launch_sum  = scoord_t'(START_X) + scoord_t'({4'b0, lfsr[8:1]});
   assign launch_x    = (launch_sum > X_LIM) ? X_LIM[COORD_W-1:0] : launch_sum[COORD_W-1:0];
`else
   assign launch_left = 1'b0;
   assign launch_x    = coord_t'(START_X);
`endif

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         xpos_q   <= coord_t'(START_X);
         ypos_q   <= coord_t'(START_Y);
         spr_q    <= SPR_FLY_R0;
         vis_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         esc_q    <= 1'b0;
         dx_neg   <= 1'b0;
         dy_neg   <= 1'b1;
         anim_cnt <= '0;
         frame    <= '0;
         fly_cnt  <= '0;
         shot_cnt <= '0;
      end else begin
         state    <= state_n;
         xpos_q   <= xpos_n;
         ypos_q   <= ypos_n;
         spr_q    <= spr_n;
         vis_q    <= vis_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         esc_q    <= esc_n;
         dx_neg   <= dx_n;
         dy_neg   <= dy_n;
         anim_cnt <= anim_n;
         frame    <= frame_n;
         fly_cnt  <= fly_n;
         shot_cnt <= shot_n;
      end
   end

   always_comb begin
      state_n = state;
      xpos_n  = xpos_q;
      ypos_n  = ypos_q;
      spr_n   = spr_q;
      vis_n   = vis_q;
      done_n  = 1'b0;
      esc_n   = 1'b0;
      dx_n    = dx_neg;
      dy_n    = dy_neg;
      anim_n  = anim_cnt;
      frame_n = frame;
      fly_n   = fly_cnt;
      shot_n  = shot_cnt;

      nx = scoord_t'({1'b0, xpos_q}) + (dx_neg ? -SX : SX);
      ny = scoord_t'({1'b0, ypos_q}) + (dy_neg ? -SY : SY);
      fy = scoord_t'({1'b0, ypos_q}) + FS;
      ey = scoord_t'({1'b0, ypos_q}) - SY;

      if (anim_cnt == ANIM_W'(ANIM_DIV - 1)) begin
         anim_adv  = '0;
         frame_adv = (frame == 2'd2) ? 2'd0 : frame + 2'd1;
      end else begin
         anim_adv  = anim_cnt + 1'b1;
         frame_adv = frame;
      end

      case (state)
         IDLE: begin
            xpos_n = coord_t'(START_X);
            ypos_n = coord_t'(START_Y);
            if (bus.start) begin
               state_n = FLY;
               xpos_n  = launch_x;
               vis_n   = 1'b1;
               dx_n    = launch_left;
               dy_n    = 1'b1;
               anim_n  = '0;
               frame_n = '0;
               fly_n   = '0;
               shot_n  = '0;
               spr_n   = fly_sprite(launch_left, 2'd0);
            end
         end
         FLY: begin
            // hit wins over a same-cycle tick, so the duck freezes where it was struck
            if (bus.hit) begin
               state_n = SHOT;
               spr_n   = SPR_SHOT;
               shot_n  = '0;
            end else if (bus.frame_tick) begin
               if (nx >= X_LIM) begin
                  xpos_n = X_LIM[COORD_W-1:0];
                  dx_n   = ~dx_neg;
               end else if (nx <= 0) begin
                  xpos_n = '0;
                  dx_n   = ~dx_neg;
               end else begin
                  xpos_n = nx[COORD_W-1:0];
               end
               if (ny >= Y_LIM) begin
                  ypos_n = Y_LIM[COORD_W-1:0];
                  dy_n   = ~dy_neg;
               end else if (ny <= 0) begin
                  ypos_n = '0;
                  dy_n   = ~dy_neg;
               end else begin
                  ypos_n = ny[COORD_W-1:0];
               end
               anim_n  = anim_adv;
               frame_n = frame_adv;
               spr_n   = fly_sprite(dx_n, frame_adv);
               fly_n   = fly_cnt + 1'b1;
               if (fly_n == FLY_W'(FLY_FRAMES)) state_n = ESCAPE;
            end
         end
         SHOT: begin
            if (bus.frame_tick) begin
               if (shot_cnt == SHOT_W'(SHOT_FRAMES - 1)) begin
                  state_n = FALL;
                  spr_n   = SPR_FALL;
               end else begin
                  shot_n = shot_cnt + 1'b1;
               end
            end
         end
         FALL: begin
            if (bus.frame_tick) begin
               if (fy >= Y_LIM) begin
                  ypos_n  = Y_LIM[COORD_W-1:0];
                  done_n  = 1'b1;
                  vis_n   = 1'b0;
                  state_n = IDLE;
               end else begin
                  ypos_n = fy[COORD_W-1:0];
               end
            end
         end
         ESCAPE: begin
            if (bus.frame_tick) begin
               anim_n  = anim_adv;
               frame_n = frame_adv;
               spr_n   = fly_sprite(dx_neg, frame_adv);
               if (ey < 0) begin
                  ypos_n  = '0;
                  esc_n   = 1'b1;
                  vis_n   = 1'b0;
                  state_n = IDLE;
               end else begin
                  ypos_n = ey[COORD_W-1:0];
               end
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   assign bus.xpos      = xpos_q;
   assign bus.ypos      = ypos_q;
   assign bus.sprite_id = spr_q;
   assign bus.visible   = vis_q;
   assign bus.busy      = busy_q;
   assign bus.shot_done = done_q;
   assign bus.escaped   = esc_q;

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Randomised bench for duck_flight_ctrl: two instances (default and START_X=730) against a frame-level model.
module tb_duck_flight_ctrl;

   typedef enum int {M_IDLE, M_FLY, M_SHOT, M_FALL, M_ESC} phase_t;

   localparam int X_LIM = 800 - 64;
   localparam int Y_LIM = 450 - 64;

   logic aclk;
   logic rst;

   duck_flight_ctrl_if bus0 ();
   duck_flight_ctrl_if bus1 ();

   assign bus1.frame_tick = bus0.frame_tick;
   assign bus1.start      = bus0.start;
   assign bus1.hit        = bus0.hit;

   duck_flight_ctrl dut0 (
      .aclk (aclk),
      .rst  (rst),
      .bus  (bus0)
   );

   duck_flight_ctrl #(.START_X(730)) dut1 (
      .aclk (aclk),
      .rst  (rst),
      .bus  (bus1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int     start_x[2] = '{100, 730};
   phase_t m_ph[2];
   int     m_x[2], m_y[2], m_dx[2], m_dy[2], m_spr[2];
   int     m_fly[2], m_anim[2], m_shot[2];
   bit     m_vis[2], m_done[2], m_esc[2];

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: time limit reached before the bench finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ph[k]   = M_IDLE;
         m_x[k]    = start_x[k];
         m_y[k]    = 100;
         m_dx[k]   = 1;
         m_dy[k]   = -1;
         m_spr[k]  = 0;
         m_fly[k]  = 0;
         m_anim[k] = 0;
         m_shot[k] = 0;
         m_vis[k]  = 1'b0;
         m_done[k] = 1'b0;
         m_esc[k]  = 1'b0;
      end
   endtask

   // Animation frame is simply (ticks since launch / 8) mod 3, offset by 3 when heading left.
   function automatic int fly_spr(input int k);
      return (m_anim[k] / 8) % 3 + ((m_dx[k] < 0) ? 3 : 0);
   endfunction

   task automatic model_step(input int k, input bit tick, input bit st, input bit ht);
      int nx, ny;
      m_done[k] = 1'b0;
      m_esc[k]  = 1'b0;
      case (m_ph[k])
         M_IDLE: begin
            m_x[k] = start_x[k];
            m_y[k] = 100;
            if (st) begin
               m_ph[k] = M_FLY;  m_vis[k] = 1'b1;
               m_dx[k] = 1;      m_dy[k] = -1;
               m_fly[k] = 0;     m_anim[k] = 0;  m_spr[k] = 0;
            end
         end
         M_FLY: begin
            if (ht) begin
               m_ph[k] = M_SHOT; m_shot[k] = 0; m_spr[k] = 6;
            end else if (tick) begin
               nx = m_x[k] + 2 * m_dx[k];
               ny = m_y[k] + 2 * m_dy[k];
               if (nx >= X_LIM)  begin m_x[k] = X_LIM; m_dx[k] = -m_dx[k]; end
               else if (nx <= 0) begin m_x[k] = 0;     m_dx[k] = -m_dx[k]; end
               else m_x[k] = nx;
               if (ny >= Y_LIM)  begin m_y[k] = Y_LIM; m_dy[k] = -m_dy[k]; end
               else if (ny <= 0) begin m_y[k] = 0;     m_dy[k] = -m_dy[k]; end
               else m_y[k] = ny;
               m_anim[k]++;
               m_fly[k]++;
               m_spr[k] = fly_spr(k);
               if (m_fly[k] == 600) m_ph[k] = M_ESC;
            end
         end
         M_SHOT: begin
            if (tick) begin
               m_shot[k]++;
               if (m_shot[k] == 30) begin m_ph[k] = M_FALL; m_spr[k] = 7; end
            end
         end
         M_FALL: begin
            if (tick) begin
               ny = m_y[k] + 4;
               if (ny >= Y_LIM) begin
                  m_y[k] = Y_LIM; m_done[k] = 1'b1; m_vis[k] = 1'b0; m_ph[k] = M_IDLE;
               end else m_y[k] = ny;
            end
         end
         M_ESC: begin
            if (tick) begin
               m_anim[k]++;
               m_spr[k] = fly_spr(k);
               ny = m_y[k] - 2;
               if (ny < 0) begin
                  m_y[k] = 0; m_esc[k] = 1'b1; m_vis[k] = 1'b0; m_ph[k] = M_IDLE;
               end else m_y[k] = ny;
            end
         end
         default: m_ph[k] = M_IDLE;
      endcase
   endtask

   function automatic logic [31:0] exp_pack(input int k);
      return {3'b0, 11'(m_x[k]), 11'(m_y[k]), 3'(m_spr[k]),
              m_vis[k], m_ph[k] != M_IDLE, m_done[k], m_esc[k]};
   endfunction

   task automatic compare_all();
      check("outs0", {3'b0, bus0.xpos, bus0.ypos, bus0.sprite_id, bus0.visible,
                      bus0.busy, bus0.shot_done, bus0.escaped}, exp_pack(0));
      check("outs1", {3'b0, bus1.xpos, bus1.ypos, bus1.sprite_id, bus1.visible,
                      bus1.busy, bus1.shot_done, bus1.escaped}, exp_pack(1));
   endtask

   task automatic step(input bit tick, input bit st, input bit ht);
      bus0.frame_tick = tick;
      bus0.start      = st;
      bus0.hit        = ht;
      @(posedge aclk);
      for (int k = 0; k < 2; k++) model_step(k, tick, st, ht);
      #1;
      compare_all();
   endtask

   task automatic run_round(input int hit_div);
      int n;
      bit tk, st, ht;
      n = 0;
      step(1'b0, 1'b1, 1'b0);
      while ((m_ph[0] != M_IDLE || m_ph[1] != M_IDLE) && n < 5000) begin
         tk = ($urandom_range(0, 1) == 1);
         ht = (hit_div != 0) && ($urandom_range(0, hit_div - 1) == 0);
         st = (m_ph[0] != M_IDLE) && (m_ph[1] != M_IDLE) && ($urandom_range(0, 15) == 0);
         step(tk, st, ht);
         n++;
      end
      check("round_idle0", bus0.busy, 0);
      check("round_idle1", bus1.busy, 0);
   endtask

   int hit_divs[10] = '{0, 300, 100, 1000, 30, 0, 500, 60, 2000, 10};

   initial begin
      int n;
      int xs, ys;
      rst             = 1'b0;
      bus0.frame_tick = 1'b0;
      bus0.start      = 1'b0;
      bus0.hit        = 1'b0;
      model_reset();

      // reset with no clock edge yet
      #2 rst = 1'b1;
      #1;
      check("rst_x", bus0.xpos, 100);
      check("rst_y", bus0.ypos, 100);
      check("rst_spr", bus0.sprite_id, 0);
      check("rst_vis", bus0.visible, 0);
      check("rst_busy", bus0.busy, 0);
      compare_all();
      @(posedge aclk);
      #1 rst = 1'b0;

      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);

      // launch, flight, right bounce on the second instance
      step(1'b0, 1'b1, 1'b0);
      repeat (3) begin
         step(1'b0, 1'b0, 1'b0);
         step(1'b1, 1'b0, 1'b0);
      end
      check("fly3_x", bus0.xpos, 106);
      check("fly3_y", bus0.ypos, 94);
      check("bounce3_x", bus1.xpos, 736);
      step(1'b1, 1'b0, 1'b0);
      check("bounce4_x", bus1.xpos, 734);
      check("bounce4_spr", bus1.sprite_id, 3);
      repeat (4) step(1'b1, 1'b0, 1'b0);
      check("anim8_spr", bus0.sprite_id, 1);
      repeat (2) step(1'b1, 1'b0, 1'b0);

      // hit with a same-cycle tick at (120,80)
      step(1'b1, 1'b0, 1'b1);
      check("shot_x", bus0.xpos, 120);
      check("shot_y", bus0.ypos, 80);
      check("shot_spr", bus0.sprite_id, 6);
      repeat (29) step(1'b1, 1'b0, 1'b1);
      check("shot29_spr", bus0.sprite_id, 6);
      step(1'b1, 1'b0, 1'b0);
      check("fall_spr", bus0.sprite_id, 7);
      check("fall_y0", bus0.ypos, 80);
      step(1'b1, 1'b0, 1'b0);
      check("fall_y1", bus0.ypos, 84);

      // start pulses during the fall are ignored
      n = 0;
      while (m_ph[0] != M_IDLE && n < 400) begin
         step(1'b1, (n % 5) == 2, 1'b0);
         n++;
      end
      check("land_done", bus0.shot_done, 1);
      check("land_y", bus0.ypos, 386);
      check("land_vis", bus0.visible, 0);
      check("land_busy", bus0.busy, 0);
      step(1'b1, 1'b0, 1'b0);
      check("done_one_cycle", bus0.shot_done, 0);
      check("idle_reload_x", bus0.xpos, 100);

      foreach (hit_divs[i]) run_round(hit_divs[i]);

      // long flight into escape, then reset in the middle of it
      step(1'b0, 1'b1, 1'b0);
      n = 0;
      while (m_ph[0] == M_FLY && n < 2000) begin
         step(1'b1, 1'b0, 1'b0);
         n++;
         if (n == 16) check("anim16_spr", bus0.sprite_id, 2);
         if (n == 24) check("anim24_spr", bus0.sprite_id, 0);
      end
      check("esc_busy", bus0.busy, 1);
      xs = m_x[0];
      ys = m_y[0];
      repeat (10) step(1'b1, 1'b0, 1'b0);
      check("esc_x_frozen", bus0.xpos, xs);
      check("esc_y_rise", bus0.ypos, ys - 20);

      #2 rst = 1'b1;
      #1;
      model_reset();
      check("midrst_x", bus0.xpos, 100);
      check("midrst_y", bus0.ypos, 100);
      check("midrst_esc", bus0.escaped, 0);
      check("midrst_busy", bus0.busy, 0);
      compare_all();
      @(posedge aclk);
      #1 rst = 1'b0;
      repeat (5) step(1'b1, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
